hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the in-flight writer slots tracked (slot 0=EX, 1=MEM, ..., DEPTH-1=WB).
REQ-002 SHALL have parameter LOAD_SLOT, default 2, meaning the first slot whose result includes load data.
REQ-003 SHALL have parameter FWD_EN, default 1, meaning operand forwarding exists (0 means stall-only mode).
REQ-004 SHALL have parameter REG_AW, default 5, meaning the register address width.
REQ-005 SHALL have parameter CNT_W, default 32, meaning the stall counter width.
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_reg_write  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (taken branch or jump)
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX (combinational)
- id_wb_byp_a, id_wb_byp_b  out  1  ID read data must take the WB write data (combinational)
- ex_fwd_a, ex_fwd_b  out  clog2(DEPTH)  registered forward select for the instruction now in EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

Function
REQ-007 SHALL keep a DEPTH-entry shift register of {valid, rd, reg_write, is_load}; every clock each entry moves to slot+1 and slot DEPTH-1 retires.
REQ-008 SHALL load slot 0 with the ID entry when id_valid && !stall && !flush, and with an invalid bubble otherwise.
REQ-009 SHALL treat a source as matching slot i only when use bit=1, slot valid, reg_write=1, rd==source, and source!=0.
REQ-010 SHALL give priority to the smallest-index (youngest) matching slot when several slots match.
REQ-011 With FWD_EN=1, SHALL assert stall when the youngest match is a load at slot i with i+1 < LOAD_SLOT.
REQ-012 With FWD_EN=0, SHALL assert stall when any match lies in slots 0..DEPTH-2.
REQ-013 SHALL assert id_wb_byp_x when the youngest match is slot DEPTH-1 and stall is 0.
REQ-014 On a non-stalled, non-flushed issue, SHALL register ex_fwd_x = i+1 for a youngest match at slot i ≤ DEPTH-2 (FWD_EN=1), else 0.
REQ-015 SHALL encode forward select 0 = register file, k = result held in slot k.
REQ-016 SHALL register ex_fwd_a and ex_fwd_b as 0 when a bubble enters slot 0.
REQ-017 SHALL give flush priority over stall: stall output=0, no push, stall_cnt unchanged.
REQ-018 SHALL force stall=0 and byp=0 when id_valid=0.
REQ-019 SHALL increment stall_cnt once per cycle with stall=1, saturating at all-ones.

Reset
REQ-020 On clk edge with reset=1, SHALL clear all slots to invalid, set ex_fwd_a/b=0 and stall_cnt=0; consequently stall and byp are 0 in the following cycle, and reset asserted mid-stall abandons the stall.

Structure
REQ-021 SHALL place the default parameters and the forward-select constants FWD_RF=0, FWD_MEM=1, FWD_WB=2 in shared package hazard_pkg.
REQ-022 SHALL instantiate one sub-module, sb_slot_match, per slot, producing match_a/match_b for that slot.

Verification
REQ-023 Issue add r3 then add r4,r3,r1 back-to-back -> stall=0; ex_fwd_a=1 in the consumer's EX cycle.
REQ-024 Issue lw r5 then add r6,r1,r5 -> stall=1 for exactly one cycle, one bubble, ex_fwd_b=2, stall_cnt=1.
REQ-025 Issue add r7, two unrelated ops, then sub r8,r7,r2 -> id_wb_byp_a=1 in the consumer's ID cycle, ex_fwd_a=0.
REQ-026 Issue add r2 twice, then or r9,r2,r2 -> ex_fwd_a=ex_fwd_b=1 (youngest wins); with rd=r0 and rs=r0 -> no stall, fwd 0.
REQ-027 Issue lw r5, then consumer of r5 with flush=1 -> stall=0, slot 0 is a bubble, stall_cnt unchanged.
REQ-028 Assert reset during a load-use stall -> next cycle stall=0, all fwd=0, stall_cnt=0; FWD_EN=0 dependent add -> stall=2 cycles, then byp=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared defaults and forward-select encoding for the hazard scoreboard.
package hazard_pkg;
  localparam int unsigned DEPTH_DEFAULT     = 3;
  localparam int unsigned LOAD_SLOT_DEFAULT = 2;
  localparam bit          FWD_EN_DEFAULT    = 1'b1;
  localparam int unsigned REG_AW_DEFAULT    = 5;
  localparam int unsigned CNT_W_DEFAULT     = 32;

  // Forward select: 0 reads the register file, k takes the result held in slot k.
  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_MEM = 1;
  localparam int unsigned FWD_WB  = 2;
endpackage

// File: rtl/sb_slot_match.sv
// Per-slot RAW comparator: does this in-flight writer produce either ID source?
module sb_slot_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              slot_valid,
  input  logic              slot_reg_write,
  input  logic [REG_AW-1:0] slot_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  output logic              match_a,
  output logic              match_b
);
  logic writer;

  // r0 is hardwired zero, so it never carries a dependency.
  assign writer  = slot_valid && slot_reg_write;
  assign match_a = use_rs1 && writer && (slot_rd == rs1) && (rs1 != '0);
  assign match_b = use_rs2 && writer && (slot_rd == rs2) && (rs2 != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight writers and resolves ID-stage RAW hazards through stall,
// WB bypass at ID, and registered forward selects for the instruction in EX.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned LOAD_SLOT = LOAD_SLOT_DEFAULT,
  parameter bit          FWD_EN    = FWD_EN_DEFAULT,
  parameter int unsigned REG_AW    = REG_AW_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic                     id_wb_byp_a,
  output logic                     id_wb_byp_b,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_a,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_b,
  output logic [CNT_W-1:0]         stall_cnt
);
  localparam int unsigned FW = $clog2(DEPTH);

  logic [DEPTH-1:0]  slot_valid, slot_reg_write, slot_is_load;
  logic [REG_AW-1:0] slot_rd [DEPTH];
  logic [DEPTH-1:0]  match_a, match_b, young_a, young_b;
  logic              src_stall_a, src_stall_b, push;
  logic [FW-1:0]     fwd_nxt_a, fwd_nxt_b;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    sb_slot_match #(.REG_AW(REG_AW)) u_match (
      .slot_valid     (slot_valid[g]),
      .slot_reg_write (slot_reg_write[g]),
      .slot_rd        (slot_rd[g]),
      .rs1            (id_rs1),
      .rs2            (id_rs2),
      .use_rs1        (id_use_rs1),
      .use_rs2        (id_use_rs2),
      .match_a        (match_a[g]),
      .match_b        (match_b[g])
    );
  end

  always_comb begin
    logic seen_a, seen_b;
    seen_a      = 1'b0;
    seen_b      = 1'b0;
    young_a     = '0;
    young_b     = '0;
    src_stall_a = 1'b0;
    src_stall_b = 1'b0;
    fwd_nxt_a   = FW'(FWD_RF);
    fwd_nxt_b   = FW'(FWD_RF);
    // One-hot youngest match per source: the lowest-index slot wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      young_a[i] = match_a[i] && !seen_a;
      young_b[i] = match_b[i] && !seen_b;
      seen_a     = seen_a || match_a[i];
      seen_b     = seen_b || match_b[i];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (FWD_EN) begin
        if (young_a[i] && slot_is_load[i] && (i + 1 < LOAD_SLOT)) src_stall_a = 1'b1;
        if (young_b[i] && slot_is_load[i] && (i + 1 < LOAD_SLOT)) src_stall_b = 1'b1;
        // Producer advances one slot by the time the consumer reaches EX.
        if (young_a[i] && (i < DEPTH - 1)) fwd_nxt_a = FW'(i + 1);
        if (young_b[i] && (i < DEPTH - 1)) fwd_nxt_b = FW'(i + 1);
      end else begin
        if (match_a[i] && (i < DEPTH - 1)) src_stall_a = 1'b1;
        if (match_b[i] && (i < DEPTH - 1)) src_stall_b = 1'b1;
      end
    end
  end

  assign stall       = id_valid && !flush && (src_stall_a || src_stall_b);
  assign push        = id_valid && !stall && !flush;
  assign id_wb_byp_a = id_valid && !stall && young_a[DEPTH-1];
  assign id_wb_byp_b = id_valid && !stall && young_b[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid     <= '0;
      slot_reg_write <= '0;
      slot_is_load   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slot_rd[i] <= '0;
      ex_fwd_a       <= FW'(FWD_RF);
      ex_fwd_b       <= FW'(FWD_RF);
      stall_cnt      <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slot_valid[i]     <= slot_valid[i-1];
        slot_reg_write[i] <= slot_reg_write[i-1];
        slot_is_load[i]   <= slot_is_load[i-1];
        slot_rd[i]        <= slot_rd[i-1];
      end
      slot_valid[0]     <= push;
      slot_reg_write[0] <= push && id_reg_write;
      slot_is_load[0]   <= push && id_is_load;
      slot_rd[0]        <= push ? id_rd : '0;
      ex_fwd_a          <= push ? fwd_nxt_a : FW'(FWD_RF);
      ex_fwd_b          <= push ? fwd_nxt_b : FW'(FWD_RF);
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a forwarding instance and a stall-only instance with a
// 3-bit counter share one stimulus stream and are checked against an age model.
module tb_hazard_scoreboard;
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic        f_stall, f_byp_a, f_byp_b;
  logic [1:0]  f_fwd_a, f_fwd_b;
  logic [31:0] f_cnt;
  logic        s_stall, s_byp_a, s_byp_b;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [2:0]  s_cnt;

  hazard_scoreboard u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(f_stall), .id_wb_byp_a(f_byp_a), .id_wb_byp_b(f_byp_b),
    .ex_fwd_a(f_fwd_a), .ex_fwd_b(f_fwd_b), .stall_cnt(f_cnt)
  );

  hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(3)) u_stl (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(s_stall), .id_wb_byp_a(s_byp_a), .id_wb_byp_b(s_byp_b),
    .ex_fwd_a(s_fwd_a), .ex_fwd_b(s_fwd_b), .stall_cnt(s_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model state per instance (0 = forwarding, 1 = stall-only):
  // hist[m][k] is the writer that left ID k+1 cycles ago (k=0 in EX, k=2 in WB).
  ent_t   hist[2][3];
  longint m_efa[2], m_efb[2], m_cnt[2];
  bit     m_ok = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int youngest(input int m, input int src, input bit used);
    if (!used || src == 0) return -1;
    for (int k = 0; k < 3; k++)
      if (hist[m][k].v && hist[m][k].rw && hist[m][k].rd == src) return k;
    return -1;
  endfunction

  function automatic bit src_stall(input int m, input int age);
    if (age < 0) return 1'b0;
    if (m == 1) return age <= 1;          // no forwarding: wait until the writer is in WB
    return hist[m][age].ld && (age + 1 < 2);  // load data exists only from slot 2 on
  endfunction

  task automatic model_eval(input int m, output bit st, output bit ba, output bit bb,
                            output int fa, output int fb);
    int ya, yb;
    ya = youngest(m, int'(id_rs1), id_use_rs1);
    yb = youngest(m, int'(id_rs2), id_use_rs2);
    st = id_valid && !flush && (src_stall(m, ya) || src_stall(m, yb));
    ba = id_valid && !st && (ya == 2);
    bb = id_valid && !st && (yb == 2);
    fa = (m == 0 && ya >= 0 && ya <= 1) ? ya + 1 : 0;
    fb = (m == 0 && yb >= 0 && yb <= 1) ? yb + 1 : 0;
  endtask

  always @(negedge clk) begin : compare
    bit     st, ba, bb, push;
    int     fa, fb;
    longint cmax;
    for (int m = 0; m < 2; m++) begin
      model_eval(m, st, ba, bb, fa, fb);
      if (m_ok) begin
        if (m == 0) begin
          chk("fwd.stall", f_stall, st);
          chk("fwd.byp_a", f_byp_a, ba);
          chk("fwd.byp_b", f_byp_b, bb);
          chk("fwd.ex_fwd_a", f_fwd_a, m_efa[0]);
          chk("fwd.ex_fwd_b", f_fwd_b, m_efb[0]);
          chk("fwd.stall_cnt", f_cnt, m_cnt[0]);
        end else begin
          chk("stl.stall", s_stall, st);
          chk("stl.byp_a", s_byp_a, ba);
          chk("stl.byp_b", s_byp_b, bb);
          chk("stl.ex_fwd_a", s_fwd_a, m_efa[1]);
          chk("stl.ex_fwd_b", s_fwd_b, m_efb[1]);
          chk("stl.stall_cnt", s_cnt, m_cnt[1]);
        end
      end
      cmax = (m == 0) ? 64'hFFFF_FFFF : 64'd7;
      if (reset) begin
        for (int k = 0; k < 3; k++) hist[m][k] = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
        m_efa[m] = 0;
        m_efb[m] = 0;
        m_cnt[m] = 0;
      end else begin
        push = id_valid && !st && !flush;
        for (int k = 2; k > 0; k--) hist[m][k] = hist[m][k-1];
        if (push) hist[m][0] = '{v: 1'b1, rd: int'(id_rd), rw: id_reg_write, ld: id_is_load};
        else      hist[m][0] = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
        m_efa[m] = push ? fa : 0;
        m_efb[m] = push ? fb : 0;
        if (st && m_cnt[m] < cmax) m_cnt[m]++;
      end
    end
    if (reset) m_ok = 1'b1;
  end

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit fl, input bit rst);
    @(posedge clk);
    #1;
    id_valid = v;  id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0];
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd[4:0];
    id_reg_write = rw; id_is_load = ld; flush = fl; reset = rst;
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    drive(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0);
  endtask

  task automatic lw(input int rd);
    drive(1, 0, 0, 0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin : stim
    longint snap;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    chk("rst.stall", f_stall, 0);
    chk("rst.fwd_a", f_fwd_a, 0);
    chk("rst.fwd_b", f_fwd_b, 0);
    chk("rst.cnt", f_cnt, 0);
    chk("rst.stl_cnt", s_cnt, 0);

    // ALU -> dependent ALU back to back
    alu(3, 1, 2);
    alu(4, 3, 1);
    chk("alu_alu.stall", f_stall, 0);
    nop();
    chk("alu_alu.fwd_a", f_fwd_a, 1);
    chk("alu_alu.fwd_b", f_fwd_b, 0);
    drain();

    // load-use: one stall, one bubble, forward from WB slot
    lw(5);
    chk("load_use.prod_stall", f_stall, 0);
    alu(6, 1, 5);
    chk("load_use.stall", f_stall, 1);
    chk("load_use.cnt_before", f_cnt, 0);
    alu(6, 1, 5);
    chk("load_use.stall_released", f_stall, 0);
    chk("load_use.cnt", f_cnt, 1);
    chk("load_use.bubble_fwd_b", f_fwd_b, 0);
    nop();
    chk("load_use.fwd_b", f_fwd_b, 2);
    chk("load_use.fwd_a", f_fwd_a, 0);
    drain();

    // writer reaches WB while the consumer is in ID
    alu(7, 1, 2);
    alu(10, 11, 12);
    alu(12, 13, 14);
    alu(8, 7, 2);
    chk("wb_byp.byp_a", f_byp_a, 1);
    chk("wb_byp.byp_b", f_byp_b, 0);
    chk("wb_byp.stall", f_stall, 0);
    nop();
    chk("wb_byp.fwd_a", f_fwd_a, 0);
    drain();

    // youngest writer wins; r0 never depends
    alu(2, 1, 1);
    alu(2, 1, 1);
    alu(9, 2, 2);
    chk("youngest.stall", f_stall, 0);
    chk("youngest.byp_a", f_byp_a, 0);
    nop();
    chk("youngest.fwd_a", f_fwd_a, 1);
    chk("youngest.fwd_b", f_fwd_b, 1);
    lw(0);
    alu(13, 0, 0);
    chk("r0.stall", f_stall, 0);
    nop();
    chk("r0.fwd_a", f_fwd_a, 0);
    chk("r0.fwd_b", f_fwd_b, 0);
    drain();

    // flush beats stall and pushes a bubble
    snap = f_cnt;
    lw(5);
    drive(1, 1, 5, 1, 1, 20, 1, 0, 1, 0);
    chk("flush.stall", f_stall, 0);
    alu(21, 20, 5);
    chk("flush.next_stall", f_stall, 0);
    chk("flush.cnt", f_cnt, snap);
    nop();
    chk("flush.bubble_fwd_a", f_fwd_a, 0);
    chk("flush.fwd_b", f_fwd_b, 2);
    drain();

    // reset in the middle of a load-use stall
    lw(5);
    drive(1, 1, 5, 1, 1, 6, 1, 0, 0, 1);
    chk("rst_stall.stall", f_stall, 1);
    alu(6, 1, 5);
    chk("rst_stall.after", f_stall, 0);
    chk("rst_stall.byp_b", f_byp_b, 0);
    chk("rst_stall.fwd_a", f_fwd_a, 0);
    chk("rst_stall.fwd_b", f_fwd_b, 0);
    chk("rst_stall.cnt", f_cnt, 0);
    chk("rst_stall.stl_cnt", s_cnt, 0);
    drain();

    // stall-only instance: dependent ALU waits two cycles, then bypasses
    alu(3, 1, 2);
    alu(4, 3, 1);
    chk("stl.dep_stall1", s_stall, 1);
    alu(4, 3, 1);
    chk("stl.dep_stall2", s_stall, 1);
    alu(4, 3, 1);
    chk("stl.dep_release", s_stall, 0);
    chk("stl.dep_byp_a", s_byp_a, 1);
    chk("stl.dep_cnt", s_cnt, 2);
    repeat (3) begin
      alu(3, 1, 2);
      repeat (3) alu(4, 3, 1);
    end
    nop();
    chk("stl.cnt_saturated", s_cnt, 7);
    drain();

    repeat (1500) begin
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0);
    end
    nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
